// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two
// requesters. One operation is in flight at a time: the operands are
// registered onto the ALU in IDLE, the ALU result and flags are captured at
// the end of EXEC, and the response is held in RESP until the owner takes it.
module alu_arbiter #(
  parameter int W   = 12,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,

  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic [OPW-1:0] req0_op,

  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  input  logic [OPW-1:0] req1_op,

  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [W-1:0]   rsp0_z,
  output logic [2:0]     rsp0_flags,

  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [W-1:0]   rsp1_z,
  output logic [2:0]     rsp1_flags,

  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_z,
  input  logic           alu_carry,
  input  logic           alu_sign,
  input  logic           alu_ov,

  output logic           busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Registered state and its next-state values.
  state_t         state_q,      state_d;
  logic           owner_q,      owner_d;      // 0: req0, 1: req1
  logic           last_q,       last_d;       // requester served last
  logic [W-1:0]   alu_a_q,      alu_a_d;
  logic [W-1:0]   alu_b_q,      alu_b_d;
  logic [OPW-1:0] alu_op_q,     alu_op_d;
  logic [W-1:0]   rsp_z_q,      rsp_z_d;
  logic [2:0]     rsp_flags_q,  rsp_flags_d;
  logic           rsp0_valid_q, rsp0_valid_d;
  logic           rsp1_valid_q, rsp1_valid_d;
  logic           busy_q,       busy_d;

  // Grant decisions (only meaningful in IDLE).
  logic           gnt0;
  logic           gnt1;
  logic           rsp_done;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end else begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // Response completion: the owner's ready while its response is presented.
  always_comb begin
    rsp_done = 1'b0;
    if (state_q == ST_RESP) begin
      if (owner_q) begin
        rsp_done = rsp1_ready;
      end else begin
        rsp_done = rsp0_ready;
      end
    end else begin
      rsp_done = 1'b0;
    end
  end

  // Next-state logic for the IDLE -> EXEC -> RESP sequence and its datapath.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_z_d      = rsp_z_q;
    rsp_flags_d  = rsp_flags_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt0) begin
          alu_a_d  = req0_a;
          alu_b_d  = req0_b;
          alu_op_d = req0_op;
          owner_d  = 1'b0;
          state_d  = ST_EXEC;
        end else if (gnt1) begin
          alu_a_d  = req1_a;
          alu_b_d  = req1_b;
          alu_op_d = req1_op;
          owner_d  = 1'b1;
          state_d  = ST_EXEC;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_EXEC: begin
        // The ALU has had a full cycle to settle on the registered operands.
        rsp_z_d      = alu_z;
        rsp_flags_d  = {alu_carry, alu_sign, alu_ov};
        rsp0_valid_d = ~owner_q;
        rsp1_valid_d = owner_q;
        state_d      = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_done) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          last_d       = owner_q;
          state_d      = ST_IDLE;
        end else begin
          state_d      = ST_RESP;
        end
      end

      default: begin
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, operand and response registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      alu_a_q      <= {W{1'b0}};
      alu_b_q      <= {W{1'b0}};
      alu_op_q     <= {OPW{1'b0}};
      rsp_z_q      <= {W{1'b0}};
      rsp_flags_q  <= 3'b000;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_z_q      <= rsp_z_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      busy_q       <= busy_d;
    end
  end

  // Output mapping; both response channels share the captured result.
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_z     = rsp_z_q;
  assign rsp1_z     = rsp_z_q;
  assign rsp0_flags = rsp_flags_q;
  assign rsp1_flags = rsp_flags_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table-driven bench for alu_arbiter with a small
// combinational ALU attached to the alu_* port.
module tb_alu_arbiter;

  localparam int W   = 12;
  localparam int OPW = 3;

  logic           clk;
  logic           rst;
  logic           req0_valid, req0_ready;
  logic [W-1:0]   req0_a, req0_b;
  logic [OPW-1:0] req0_op;
  logic           req1_valid, req1_ready;
  logic [W-1:0]   req1_a, req1_b;
  logic [OPW-1:0] req1_op;
  logic           rsp0_valid, rsp0_ready;
  logic [W-1:0]   rsp0_z;
  logic [2:0]     rsp0_flags;
  logic           rsp1_valid, rsp1_ready;
  logic [W-1:0]   rsp1_z;
  logic [2:0]     rsp1_flags;
  logic [W-1:0]   alu_a, alu_b, alu_z;
  logic [OPW-1:0] alu_op;
  logic           alu_carry, alu_sign, alu_ov;
  logic           busy;

  int errors;
  int checks;

  alu_arbiter #(.W(W), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_z(rsp0_z), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_z(rsp1_z), .rsp1_flags(rsp1_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_z(alu_z), .alu_carry(alu_carry), .alu_sign(alu_sign), .alu_ov(alu_ov),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: 0 A, 1 B, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 ADD, 7 SUB (carry = borrow).
  logic [W:0] alu_wide;
  always_comb begin
    alu_wide  = {(W+1){1'b0}};
    alu_carry = 1'b0;
    alu_ov    = 1'b0;
    case (alu_op)
      3'd0: alu_wide = {1'b0, alu_a};
      3'd1: alu_wide = {1'b0, alu_b};
      3'd2: alu_wide = {1'b0, alu_a & alu_b};
      3'd3: alu_wide = {1'b0, alu_a | alu_b};
      3'd4: alu_wide = {1'b0, alu_a ^ alu_b};
      3'd5: alu_wide = {1'b0, ~alu_a};
      3'd6: begin
        alu_wide  = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry = alu_wide[W];
        alu_ov    = (alu_a[W-1] == alu_b[W-1]) && (alu_wide[W-1] != alu_a[W-1]);
      end
      3'd7: begin
        alu_wide  = {1'b0, alu_a} - {1'b0, alu_b};
        alu_carry = alu_wide[W];
        alu_ov    = (alu_a[W-1] != alu_b[W-1]) && (alu_wide[W-1] != alu_a[W-1]);
      end
      default: alu_wide = {(W+1){1'b0}};
    endcase
    alu_z    = alu_wide[W-1:0];
    alu_sign = alu_wide[W-1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic           port;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [OPW-1:0] op;
    logic [W-1:0]   exp_z;
    logic [2:0]     exp_flags;   // {carry, sign, ov}
  } vec_t;

  vec_t vecs [8];

  // Drive one request on the chosen port (call just after a negedge).
  task automatic drive_req(input logic port, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [OPW-1:0] op);
    if (port) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  // Full transaction with rsp ready high: accept, EXEC, RESP, back to IDLE.
  task automatic run_vec(input vec_t v);
    drive_req(v.port, v.a, v.b, v.op);
    #1;
    chk("vec_ready_own",   v.port ? req1_ready : req0_ready, 32'd1);
    chk("vec_ready_other", v.port ? req0_ready : req1_ready, 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);                       // EXEC
    chk("exec_alu_op", alu_op, v.op);
    chk("exec_alu_a",  alu_a,  v.a);
    chk("exec_busy",   busy,   32'd1);
    chk("exec_readys", {req1_ready, req0_ready}, 32'd0);
    @(negedge clk);                       // RESP
    chk("resp_valid_own",   v.port ? rsp1_valid : rsp0_valid, 32'd1);
    chk("resp_valid_other", v.port ? rsp0_valid : rsp1_valid, 32'd0);
    chk("resp_z",     v.port ? rsp1_z : rsp0_z, v.exp_z);
    chk("resp_flags", v.port ? rsp1_flags : rsp0_flags, v.exp_flags);
    chk("resp_readys", {req1_ready, req0_ready}, 32'd0);
    @(negedge clk);                       // back in IDLE
    chk("idle_valids", {rsp1_valid, rsp0_valid}, 32'd0);
    chk("idle_busy",   busy, 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = 12'h000; req0_b = 12'h000; req0_op = 3'd0;
    req1_valid = 1'b0; req1_a = 12'h000; req1_b = 12'h000; req1_op = 3'd0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;

    vecs[0] = '{1'b0, 12'h7FF, 12'h001, 3'd6, 12'h800, 3'b011};
    vecs[1] = '{1'b1, 12'h005, 12'h007, 3'd7, 12'hFFE, 3'b110};
    vecs[2] = '{1'b0, 12'hF0F, 12'h0FF, 3'd2, 12'h00F, 3'b000};
    vecs[3] = '{1'b0, 12'hF0F, 12'h000, 3'd5, 12'h0F0, 3'b000};
    vecs[4] = '{1'b1, 12'h0A0, 12'h00A, 3'd3, 12'h0AA, 3'b000};
    vecs[5] = '{1'b0, 12'hFFF, 12'h001, 3'd6, 12'h000, 3'b100};
    vecs[6] = '{1'b1, 12'hFFF, 12'h0F0, 3'd4, 12'hF0F, 3'b010};
    vecs[7] = '{1'b0, 12'h800, 12'h001, 3'd7, 12'h7FF, 3'b001};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy",   busy, 32'd0);
    chk("rst_valids", {rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_alu_op", alu_op, 32'd0);
    chk("rst_alu_a",  alu_a,  32'd0);
    chk("rst_readys", {req1_ready, req0_ready}, 32'd0);
    @(negedge clk);

    // Table-driven operations (last one is req0, so last served = 0)
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // Reset while in RESP with rsp0 held: everything clears without an edge
    rsp0_ready = 1'b0;
    drive_req(1'b0, 12'h123, 12'h111, 3'd6);
    #1;
    chk("mr_ready0", req0_ready, 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mr_rsp0_valid", rsp0_valid, 32'd1);
    chk("mr_rsp0_z",     rsp0_z, 32'h234);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_rsp0_cleared", rsp0_valid, 32'd0);
    chk("mr_busy_cleared", busy, 32'd0);
    chk("mr_alu_op_zero",  alu_op, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rsp0_ready = 1'b1;

    // Tie: both valid continuously, grants alternate starting with req0
    drive_req(1'b0, 12'h001, 12'h002, 3'd6);
    drive_req(1'b1, 12'h010, 12'h020, 3'd6);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("tie_ready0", req0_ready, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("tie_ready1", req1_ready, (k % 2 == 1) ? 32'd1 : 32'd0);
      @(negedge clk);
      chk("tie_exec_readys", {req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
      chk("tie_rsp_owner", {rsp1_valid, rsp0_valid}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("tie_rsp_z", (k % 2 == 0) ? rsp0_z : rsp1_z, (k % 2 == 0) ? 32'h003 : 32'h030);
      chk("tie_resp_readys", {req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);

    // Backpressure on rsp1 with req0 waiting
    drive_req(1'b1, 12'h100, 12'h023, 3'd6);
    #1;
    chk("bp_ready1", req1_ready, 32'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    rsp1_ready = 1'b0;
    drive_req(1'b0, 12'h00F, 12'h0F0, 3'd3);
    @(negedge clk);
    chk("bp_exec_ready0", req0_ready, 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rsp1_valid", rsp1_valid, 32'd1);
      chk("bp_rsp1_z",     rsp1_z, 32'h123);
      chk("bp_rsp1_flags", rsp1_flags, 32'd0);
      chk("bp_ready0",     req0_ready, 32'd0);
      chk("bp_busy",       busy, 32'd1);
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_valid", rsp1_valid, 32'd0);
    chk("bp_grant0",     req0_ready, 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_rsp0_valid", rsp0_valid, 32'd1);
    chk("bp_rsp0_z",     rsp0_z, 32'h0FF);
    @(negedge clk);
    chk("bp_final_busy", busy, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
